// File: rtl/instr_fetch_queue_if.sv
// Fetch front-end bundle: instruction-memory req/ack bus, the valid/ready
// instruction stream toward the datapath, and the redirect input.
interface instr_fetch_queue_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_pc;

  // fetch unit side
  modport master (
    output mem_req, mem_addr, instr_valid, instr, instr_pc,
    input  mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
  );

  // memory + datapath side
  modport slave (
    input  mem_req, mem_addr, instr_valid, instr, instr_pc,
    output mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: one outstanding sequential fetch at a time, returned
// words buffered with their PC in a DEPTH-entry FIFO, flush/refetch on redirect.
// A redirect that lands while a fetch is in flight parks in DISCARD until the
// stale ack arrives, so the memory always sees a completed handshake.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic               clk,
  input logic               rst,
  instr_fetch_queue_if.master bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t        state, state_n;
  logic [15:0]   fetch_pc, fetch_pc_n;
  logic [15:0]   req_addr, req_addr_n;
  logic [15:0]   pc_mem   [DEPTH];
  logic [15:0]   word_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_n;
  logic          push, pop;
  logic [15:0]   rpc;
  logic          unused_rpc_bit;

  assign rpc            = {bus.redirect_pc[15:1], 1'b0};
  assign unused_rpc_bit = bus.redirect_pc[0];

  assign push    = (state == REQ) & bus.mem_ack & ~bus.redirect;
  assign pop     = (count != '0) & bus.instr_ready & ~bus.redirect;
  assign count_n = count + (AW+1)'(push) - (AW+1)'(pop);

  // Outputs straight from registers: no input-to-output combinational path
  assign bus.mem_req     = (state != IDLE);
  assign bus.mem_addr    = req_addr;
  assign bus.instr_valid = (count != '0);
  assign bus.instr       = word_mem[rd_ptr];
  assign bus.instr_pc    = pc_mem[rd_ptr];

  // Next-state, next fetch PC and next request address
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    req_addr_n = req_addr;
    case (state)
      IDLE: begin
        if (bus.redirect) begin
          fetch_pc_n = rpc;
          req_addr_n = rpc;
          state_n    = REQ;
        end else if (count < FULL) begin
          req_addr_n = fetch_pc;
          state_n    = REQ;
        end
      end
      REQ: begin
        if (bus.redirect) begin
          fetch_pc_n = rpc;
          if (bus.mem_ack) req_addr_n = rpc;   // word dropped, refetch now
          else             state_n    = DISCARD; // wait out the stale fetch
        end else if (bus.mem_ack) begin
          fetch_pc_n = req_addr + 16'd2;
          if (count_n < FULL) req_addr_n = req_addr + 16'd2;
          else                state_n    = IDLE;
        end
      end
      DISCARD: begin
        if (bus.redirect) fetch_pc_n = rpc;
        if (bus.mem_ack) begin
          req_addr_n = bus.redirect ? rpc : fetch_pc;
          state_n    = REQ;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Fetch control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      req_addr <= req_addr_n;
    end
  end

  // FIFO pointers and occupancy; a redirect flushes and overrides any pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_n;
    end
  end

  // FIFO storage: {pc, word} written on push, no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= req_addr;
      word_mem[wr_ptr] <= bus.mem_rdata;
    end
  end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
// A second instance with RESET_PC = FFFC covers PC wrap-around.
module tb_instr_fetch_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst1 = 1'b1;

  instr_fetch_queue_if bus0();
  instr_fetch_queue_if bus1();

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut0 (.clk(clk), .rst(rst),  .bus(bus0));
  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(16'hFFFC)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));

  always #5 clk = ~clk;

  // zero-wait memory and always-ready consumer for the wrap instance
  assign bus1.mem_ack     = bus1.mem_req;
  assign bus1.mem_rdata   = bus1.mem_addr ^ 16'hA5A5;
  assign bus1.instr_ready = 1'b1;
  assign bus1.redirect    = 1'b0;
  assign bus1.redirect_pc = 16'h0000;

  int n_chk = 0;
  int n_err = 0;

  // reference model: FIFO contents as a queue of {pc, word}
  logic [31:0] mq[$];
  logic        m_busy, m_stale;
  logic [15:0] m_addr, m_next;

  // stimulus bookkeeping
  int          ack_mode = 0;   // 0: fixed latency, 1: random acks
  int          lat = 1;
  int          wcnt = 0;
  int          acks = 0;
  logic [15:0] popped[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset(input logic [15:0] rpc0);
    mq.delete();
    m_busy = 1'b0; m_stale = 1'b0;
    m_addr = rpc0; m_next = rpc0;
  endtask

  // one clock of the fetch queue described as requests and a queue
  task automatic model_step(input logic ack, input logic rdy, input logic red, input logic [15:0] rpc);
    logic [15:0] r;
    int cnt;
    r   = {rpc[15:1], 1'b0};
    cnt = mq.size();
    if (red) begin
      mq.delete();
      m_next = r;
      if (m_busy && !ack) m_stale = 1'b1;
      else begin m_addr = r; m_busy = 1'b1; m_stale = 1'b0; end
    end else begin
      if (cnt > 0 && rdy) void'(mq.pop_front());
      if (m_busy && ack) begin
        if (m_stale) begin
          m_stale = 1'b0;
          m_addr  = m_next;
        end else begin
          mq.push_back({m_addr, m_addr ^ 16'hA5A5});
          m_next = m_addr + 16'd2;
          if (mq.size() < DEPTH) m_addr = m_next;
          else                   m_busy = 1'b0;
        end
      end else if (!m_busy && cnt < DEPTH) begin
        m_addr = m_next;
        m_busy = 1'b1;
      end
    end
  endtask

  // compare at negedge, drive inputs, advance model on posedge, back to negedge
  task automatic step(input logic rdy, input logic red, input logic [15:0] rpc);
    logic ack, ob;
    chk("mem_req", 32'(bus0.mem_req), 32'(m_busy));
    chk("mem_addr", 32'(bus0.mem_addr), 32'(m_addr));
    chk("instr_valid", 32'(bus0.instr_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("instr_pc", 32'(bus0.instr_pc), 32'(mq[0][31:16]));
      chk("instr", 32'(bus0.instr), 32'(mq[0][15:0]));
    end
    if (ack_mode == 0) ack = m_busy && (wcnt >= lat - 1);
    else               ack = ($urandom_range(0, 2) == 0);
    if (bus0.instr_valid && rdy && !red) popped.push_back(bus0.instr_pc);
    if (m_busy && ack) acks++;
    bus0.mem_ack     = ack;
    bus0.mem_rdata   = bus0.mem_addr ^ 16'hA5A5;
    bus0.instr_ready = rdy;
    bus0.redirect    = red;
    bus0.redirect_pc = rpc;
    @(posedge clk);
    ob = m_busy;
    model_step(ack, rdy, red, rpc);
    if (!m_busy || !ob || ack) wcnt = 0;
    else                       wcnt++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus0.mem_ack = 1'b0; bus0.mem_rdata = '0; bus0.instr_ready = 1'b0;
    bus0.redirect = 1'b0; bus0.redirect_pc = '0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", 32'(bus0.mem_req), 32'h0);
    chk("rst_instr_valid", 32'(bus0.instr_valid), 32'h0);
    chk("rst_mem_addr", 32'(bus0.mem_addr), 32'h0000);
    rst = 1'b0;
    model_reset(16'h0000);
    wcnt = 0; acks = 0; popped.delete();
  endtask

  initial begin
    bool_found: begin end
    // ---------------- reset and stream ----------------
    ack_mode = 0; lat = 1;
    do_reset();
    step(1'b1, 1'b0, '0);
    chk("cold_mem_req", 32'(bus0.mem_req), 32'h1);
    chk("cold_mem_addr", 32'(bus0.mem_addr), 32'h0000);
    step(1'b1, 1'b0, '0);
    chk("l2u_valid", 32'(bus0.instr_valid), 32'h1);
    chk("l2u_pc", 32'(bus0.instr_pc), 32'h0000);
    chk("l2u_instr", 32'(bus0.instr), 32'hA5A5);
    repeat (10) step(1'b1, 1'b0, '0);
    chk("stream_count", 32'(popped.size()), 32'd10);
    for (int i = 0; i < popped.size(); i++)
      chk("stream_pc", 32'(popped[i]), 32'(2 * i));

    // ---------------- backpressure ----------------
    do_reset();
    repeat (10) step(1'b0, 1'b0, '0);
    chk("bp_acks", 32'(acks), 32'd4);
    chk("bp_mem_req", 32'(bus0.mem_req), 32'h0);
    popped.delete();
    repeat (5) step(1'b1, 1'b0, '0);
    chk("bp_pops", 32'(popped.size()), 32'd5);
    for (int i = 0; i < 5 && i < popped.size(); i++)
      chk("bp_pc", 32'(popped[i]), 32'(2 * i));

    // ---------------- redirect while waiting ----------------
    do_reset();
    lat = 3;
    begin
      int n;
      n = 0;
      while (!(bus0.mem_req && bus0.mem_addr == 16'h0004) && n < 40) begin
        step(1'b1, 1'b0, '0);
        n++;
      end
      chk("rw_reach_0004", 32'(n < 40), 32'h1);
    end
    step(1'b1, 1'b0, '0);
    popped.delete();
    step(1'b1, 1'b1, 16'h0100);
    chk("rw_hold_addr", 32'(bus0.mem_addr), 32'h0004);
    chk("rw_hold_req", 32'(bus0.mem_req), 32'h1);
    chk("rw_valid_low", 32'(bus0.instr_valid), 32'h0);
    step(1'b1, 1'b0, '0);
    chk("rw_new_addr", 32'(bus0.mem_addr), 32'h0100);
    repeat (10) step(1'b1, 1'b0, '0);
    chk("rw_first_nonempty", 32'(popped.size() != 0), 32'h1);
    if (popped.size() != 0) chk("rw_first_pc", 32'(popped[0]), 32'h0100);
    begin
      int stale;
      stale = 0;
      foreach (popped[i]) if (popped[i] == 16'h0004) stale++;
      chk("rw_no_stale", 32'(stale), 32'h0);
    end

    // ---------------- redirect with ack and pop ----------------
    do_reset();
    lat = 1;
    repeat (3) step(1'b1, 1'b0, '0);
    chk("co_pre_valid", 32'(bus0.instr_valid), 32'h1);
    chk("co_pre_req", 32'(bus0.mem_req), 32'h1);
    step(1'b1, 1'b1, 16'h0041);
    chk("co_valid", 32'(bus0.instr_valid), 32'h0);
    chk("co_mem_addr", 32'(bus0.mem_addr), 32'h0040);
    chk("co_mem_req", 32'(bus0.mem_req), 32'h1);
    repeat (3) step(1'b1, 1'b0, '0);

    // ---------------- reset mid-request ----------------
    do_reset();
    lat = 3;
    repeat (4) step(1'b0, 1'b0, '0);
    chk("mr_pre_req", 32'(bus0.mem_req), 32'h1);
    chk("mr_pre_valid", 32'(bus0.instr_valid), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("mr_req_drop", 32'(bus0.mem_req), 32'h0);
    chk("mr_valid_drop", 32'(bus0.instr_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset(16'h0000);
    wcnt = 0;
    step(1'b1, 1'b0, '0);
    chk("mr_first_req", 32'(bus0.mem_req), 32'h1);
    chk("mr_first_addr", 32'(bus0.mem_addr), 32'h0000);
    repeat (6) step(1'b1, 1'b0, '0);

    // ---------------- random traffic ----------------
    do_reset();
    ack_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      logic rdy, red;
      logic [15:0] rp;
      rdy = ($urandom_range(0, 3) != 0);
      red = ($urandom_range(0, 15) == 0);
      rp  = 16'($urandom);
      step(rdy, red, rp);
    end

    // ---------------- wrap-around (second instance) ----------------
    @(negedge clk);
    rst1 = 1'b0;
    begin
      logic [15:0] exp_pc [4];
      logic [15:0] got [$];
      exp_pc[0] = 16'hFFFC; exp_pc[1] = 16'hFFFE; exp_pc[2] = 16'h0000; exp_pc[3] = 16'h0002;
      for (int c = 0; c < 12 && got.size() < 4; c++) begin
        @(negedge clk);
        if (bus1.instr_valid) begin
          got.push_back(bus1.instr_pc);
          chk("wrap_instr", 32'(bus1.instr), 32'(bus1.instr_pc ^ 16'hA5A5));
        end
      end
      chk("wrap_count", 32'(got.size()), 32'd4);
      for (int i = 0; i < 4 && i < got.size(); i++)
        chk("wrap_pc", 32'(got[i]), 32'(exp_pc[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch front end for the 16-bit RISC core. It generates sequential 16-bit instruction-memory requests over a req/ack handshake and buffers the returned words, each tagged with its PC, in a small FIFO. It presents them to the datapath over a valid/ready interface and flushes and restarts on a taken branch or jump (redirect) from the datapath. It sits directly upstream of the datapath and replaces the combinational PC-to-instruction-memory path.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2
- RESET_PC, 16'h0000, first fetch address after reset
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- mem_req  out  1  instruction-memory request; held high until mem_ack
- mem_addr  out  16  request address; bit 0 always 0; stable while mem_req is high
- mem_ack  in  1  transfer complete; sampled only while mem_req is high; may be high in the first cycle of a request
- mem_rdata  in  16  instruction word, valid in the mem_ack cycle
- instr_valid  out  1  FIFO head valid
- instr  out  16  head instruction word
- instr_pc  out  16  PC of the head instruction
- instr_ready  in  1  consumer takes the head this cycle when instr_valid is high
- redirect  in  1  taken branch or jump; flush and refetch
- redirect_pc  in  16  new PC; bit 0 is ignored and forced to 0

## Operation
- **Registers:**
  - fetch_pc: the next address to request.
  - req_addr: drives mem_addr.
  - state: IDLE, REQ or DISCARD.
  - FIFO of DEPTH entries of {pc, word}, with a count from 0 to DEPTH.
- **Combinational outputs:**
  - mem_req = (state != IDLE).
  - instr_valid = (count != 0).
  - instr and instr_pc come from the head entry.
- **Push, pop and count:**
  - push = (state == REQ) & mem_ack & ~redirect.
  - pop = instr_valid & instr_ready & ~redirect.
  - count_next = count + push - pop.
- **Issue:** whenever a request is issued, req_addr <= the new fetch_pc. Only one request is outstanding at a time.
- **IDLE:**
  - redirect: flush; fetch_pc <= redirect_pc; issue; go to REQ.
  - else if count < DEPTH: issue; go to REQ.
  - otherwise stay in IDLE.
- **REQ:**
  - redirect & mem_ack: word dropped; flush; fetch_pc <= redirect_pc; issue; stay in REQ.
  - redirect & ~mem_ack: flush; fetch_pc <= redirect_pc; go to DISCARD; req_addr is held.
  - mem_ack: push {req_addr, mem_rdata}; fetch_pc <= req_addr + 2.
    - If count_next < DEPTH, issue and stay in REQ.
    - Otherwise go to IDLE.
- **DISCARD:** the stale request is completed but its data is dropped.
  - A redirect here flushes and updates fetch_pc only.
  - On mem_ack: issue at the current fetch_pc (or redirect_pc if redirect is also high); go to REQ.
- **Flush:** count <= 0 and pointers <= 0. A pop requested in the same cycle as a redirect is ignored.
- **Arithmetic:** PC arithmetic is modulo 2^16, so 16'hFFFE + 2 = 16'h0000.
- **Reset:** asynchronous and immediate, including in the middle of a request.
  - state = IDLE; count = 0; fetch_pc = RESET_PC.
  - req_addr = RESET_PC, so mem_addr reads RESET_PC while reset is asserted.
  - mem_req = 0 and instr_valid = 0 while reset is asserted.
  - An outstanding memory transaction is abandoned; the memory must tolerate mem_req dropping.

## Timing
- **Cold start:** first edge after rst deasserts goes IDLE -> REQ. mem_req is high from cycle 1.
- **Load-to-use:** with a zero-wait ack in cycle n, instr_valid is high in cycle n+1.
- **Streaming:** with zero-wait memory and instr_ready held high, throughput is 1 instruction per cycle.
- **Full FIFO:** at count == DEPTH with no pop, mem_req drops the cycle after the filling ack.
  - The first pop returns the block to IDLE with count < DEPTH.
  - The next request issues one cycle after that pop.
- **Simultaneous push and pop:** count is unchanged and ordering is preserved.
- **Redirect cycle:** the cycle after a redirect, instr_valid = 0.
  - If no stale request is outstanding, mem_req is high with mem_addr = redirect_pc.
- **Stale request:** the redirected fetch is delayed until the stale mem_ack. No stale word ever reaches instr.
- **Registered paths:** mem_addr and mem_req have no combinational path from any input. instr and instr_valid have none either.

## Test plan
- **Reset and stream:** release rst with zero-wait ack and instr_ready = 1; memory returns word = address ^ 16'hA5A5.
  - Consumer sees instr_pc 0, 2, 4, 6, … one per cycle.
  - Each instr equals instr_pc ^ 16'hA5A5.
- **Backpressure:** instr_ready = 0 for 10 cycles with DEPTH = 4.
  - Exactly 4 acks occur, then mem_req = 0.
  - Raising instr_ready delivers PCs 0, 2, 4, 6 in order, followed by 8.
- **Redirect while waiting:** memory latency 3 cycles; redirect to 16'h0100 one cycle after a request to 16'h0004 issues.
  - mem_addr holds 16'h0004 until its ack.
  - The next mem_addr is 16'h0100.
  - The first delivered instr_pc is 16'h0100 and the 16'h0004 word is never delivered.
- **Redirect coincident with ack and pop:** redirect_pc = 16'h0041 in the same cycle as both.
  - The FIFO empties and the ack data is dropped.
  - The next cycle has mem_addr = 16'h0040.
- **Wrap-around:** RESET_PC = 16'hFFFC, zero-wait memory.
  - Delivered instr_pc sequence is FFFC, FFFE, 0000, 0002.
- **Reset mid-request:** assert rst while mem_req is high with no ack.
  - mem_req and instr_valid fall immediately, without waiting for a clock edge.
  - After release, the first request is to RESET_PC.
